// File: rtl/block_loader.sv
// Host-side staging stage: packs a valid/ready word stream into BLOCKWORDS-wide
// blocks and issues each as a single-cycle write to consecutive block-aligned addresses.
module block_loader #(
    parameter int ADDRSIZE  = 256,
    parameter int BITWIDTH  = 16,
    parameter int MESHUNITS = 2,
    parameter int TILEUNITS = 2
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic [BITWIDTH-1:0]                           base_addr,
    input  logic [BITWIDTH-1:0]                           num_blocks,
    input  logic                                          abort,
    input  logic signed [BITWIDTH-1:0]                    in_data,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic [BITWIDTH-1:0]                           loader_write_addr,
    output logic                                          loader_write_valid,
    output logic [MESHUNITS*MESHUNITS*TILEUNITS*TILEUNITS-1:0][BITWIDTH-1:0] loader_write_data,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          error
);

    localparam int BLOCKWORDS = MESHUNITS * MESHUNITS * TILEUNITS * TILEUNITS;
    localparam int LOG2       = $clog2(BLOCKWORDS);
    localparam int W2         = 2 * BITWIDTH;
    localparam logic [LOG2-1:0] LAST = LOG2'(BLOCKWORDS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                               state;
    logic [LOG2-1:0]                          cnt;
    logic [BITWIDTH-1:0]                      cur_addr;
    logic [BITWIDTH-1:0]                      blocks_left;
    logic [BLOCKWORDS-1:0][BITWIDTH-1:0]      buffer;
    logic [W2-1:0]                            end_addr;
    logic                                     misaligned;
    logic                                     overflow;

    // Range check at double width so base + num*BLOCKWORDS cannot wrap.
    assign end_addr   = W2'(base_addr) + (W2'(num_blocks) << LOG2);
    assign misaligned = (base_addr & BITWIDTH'(BLOCKWORDS - 1)) != '0;
    assign overflow   = end_addr > W2'(ADDRSIZE);

    assign in_ready           = (state == S_FILL);
    assign loader_write_valid = (state == S_WRITE) && !abort;
    assign busy               = (state == S_FILL) || (state == S_WRITE);
    assign done               = (state == S_DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            cnt               <= '0;
            cur_addr          <= '0;
            blocks_left       <= '0;
            buffer            <= '0;
            loader_write_addr <= '0;
            loader_write_data <= '0;
            error             <= 1'b0;
        end else begin
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (misaligned || overflow) begin
                            error <= 1'b1;
                        end else if (num_blocks == '0) begin
                            state <= S_DONE;
                        end else begin
                            cur_addr    <= base_addr;
                            blocks_left <= num_blocks;
                            cnt         <= '0;
                            state       <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (abort) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else if (in_valid) begin
                        buffer[cnt] <= in_data;
                        if (cnt == LAST) begin
                            // Output registers hold the block (incl. this last word) until the next write.
                            cnt                     <= '0;
                            loader_write_addr       <= cur_addr;
                            loader_write_data       <= buffer;
                            loader_write_data[LAST] <= in_data;
                            state                   <= S_WRITE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        cur_addr    <= cur_addr + BITWIDTH'(BLOCKWORDS);
                        blocks_left <= blocks_left - 1'b1;
                        state       <= (blocks_left == BITWIDTH'(1)) ? S_DONE : S_FILL;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_loader.sv
// Directed bench for block_loader: expected block writes are queued as stimulus is
// driven and checked against each write strobe.
module tb_block_loader;

    localparam int BW = 16;
    localparam int NW = 16;

    typedef logic [NW-1:0][BW-1:0] blk_t;
    typedef struct {
        logic [BW-1:0] addr;
        blk_t          data;
    } wr_t;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic                 in_valid = 1'b0;
    logic [BW-1:0]        base_addr = '0;
    logic [BW-1:0]        num_blocks = '0;
    logic signed [BW-1:0] in_data = '0;
    logic                 in_ready;
    logic [BW-1:0]        loader_write_addr;
    logic                 loader_write_valid;
    blk_t                 loader_write_data;
    logic                 busy;
    logic                 done;
    logic                 error;

    wr_t exp_q[$];
    wr_t mon_e;
    int  total = 0, bad = 0, cyc = 0;
    int  strobes = 0, dones = 0, errors = 0;
    int  last_strobe_cyc = -1, last_done_cyc = -1, hs_cyc = -1, first_hs = -1;
    int  s0, d0, e0;

    block_loader #(.ADDRSIZE(256), .BITWIDTH(BW), .MESHUNITS(2), .TILEUNITS(2)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .num_blocks(num_blocks), .abort(abort), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .loader_write_addr(loader_write_addr),
        .loader_write_valid(loader_write_valid), .loader_write_data(loader_write_data),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (loader_write_valid) begin
                strobes++;
                last_strobe_cyc = cyc;
                check("strobe_expected", 512'(exp_q.size() != 0), 512'(1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("write_addr", 512'(loader_write_addr), 512'(mon_e.addr));
                    check("write_data", 512'(loader_write_data), 512'(mon_e.data));
                end
            end
            if (done) begin
                dones++;
                last_done_cyc = cyc;
            end
            if (error) errors++;
        end
    end

    task automatic push_exp(input logic [BW-1:0] a, input logic [BW-1:0] v0);
        wr_t e;
        e.addr = a;
        for (int k = 0; k < NW; k++) e.data[k] = v0 + BW'(k);
        exp_q.push_back(e);
    endtask

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [BW-1:0] b, input logic [BW-1:0] n);
        start = 1'b1;
        base_addr = b;
        num_blocks = n;
        sync();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [BW-1:0] v, input bit gap);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data = v;
        @(negedge clock);
        while (!in_ready && t < 40) begin
            @(negedge clock);
            t++;
        end
        if (t >= 40) check("handshake_timeout", 512'(in_ready), 512'(1));
        hs_cyc = cyc;
        sync();
        in_valid = 1'b0;
        if (gap) sync();
    endtask

    task automatic send_block(input logic [BW-1:0] v0, input bit gap);
        for (int k = 0; k < NW; k++) begin
            send_word(v0 + BW'(k), gap);
            if (k == 0) first_hs = hs_cyc;
        end
    endtask

    task automatic wait_for_done(input int target, input int limit);
        int t;
        t = 0;
        while (dones < target && t < limit) begin
            @(negedge clock);
            t++;
        end
        check("done_count", 512'(dones), 512'(target));
    endtask

    initial begin
        // reset values
        #12;
        check("reset_flags", 512'({in_ready, loader_write_valid, busy, done, error}), 512'(0));
        check("reset_addr", 512'(loader_write_addr), 512'(0));
        check("reset_data", 512'(loader_write_data), 512'(0));
        sync();
        reset = 1'b1;
        sync();

        // single block, back-to-back
        push_exp(16'h0020, 16'd1);
        do_start(16'h0020, 16'd1);
        send_block(16'd1, 1'b0);
        wait_for_done(1, 40);
        check("t1_strobes", 512'(strobes), 512'(1));
        check("t1_strobe_after_last", 512'(last_strobe_cyc), 512'(hs_cyc + 1));
        check("t1_strobe_latency", 512'(last_strobe_cyc), 512'(first_hs + NW));
        check("t1_done_after_strobe", 512'(last_done_cyc), 512'(last_strobe_cyc + 1));
        sync();

        // three blocks with bubbles
        for (int b = 0; b < 3; b++) push_exp(BW'(b * 16), BW'(16'h0100 + b * 16));
        do_start(16'h0000, 16'd3);
        for (int b = 0; b < 3; b++) send_block(BW'(16'h0100 + b * 16), 1'b1);
        wait_for_done(2, 60);
        check("t2_strobes", 512'(strobes), 512'(4));
        check("t2_queue_empty", 512'(exp_q.size()), 512'(0));
        sync();

        // misaligned base rejected
        e0 = errors;
        do_start(16'h0008, 16'd1);
        @(negedge clock);
        check("mis_error", 512'(error), 512'(1));
        check("mis_ready", 512'(in_ready), 512'(0));
        check("mis_busy", 512'(busy), 512'(0));
        sync();
        @(negedge clock);
        check("mis_error_pulse", 512'(error), 512'(0));
        sync();

        // range overflow rejected
        do_start(16'h00F0, 16'd2);
        @(negedge clock);
        check("ovf_error", 512'(error), 512'(1));
        check("ovf_ready", 512'(in_ready), 512'(0));
        check("ovf_busy", 512'(busy), 512'(0));
        sync();
        check("err_count", 512'(errors), 512'(e0 + 2));

        // exactly reaching ADDRSIZE is accepted; then abort in FILL
        d0 = dones;
        do_start(16'h00F0, 16'd1);
        @(negedge clock);
        check("edge_busy", 512'(busy), 512'(1));
        check("edge_ready", 512'(in_ready), 512'(1));
        check("edge_error", 512'(error), 512'(0));
        abort = 1'b1;
        sync();
        abort = 1'b0;
        @(negedge clock);
        check("abort0_busy", 512'(busy), 512'(0));
        check("abort0_ready", 512'(in_ready), 512'(0));
        sync();
        @(negedge clock);
        check("abort0_nodone", 512'(dones), 512'(d0));
        sync();

        // zero blocks: done without a write
        s0 = strobes;
        d0 = dones;
        do_start(16'h0010, 16'd0);
        @(negedge clock);
        check("zero_done", 512'(done), 512'(1));
        check("zero_busy", 512'(busy), 512'(0));
        sync();
        @(negedge clock);
        check("zero_done_pulse", 512'(done), 512'(0));
        check("zero_strobes", 512'(strobes), 512'(s0));
        check("zero_done_count", 512'(dones), 512'(d0 + 1));
        sync();

        // abort at word 9 of block 2
        s0 = strobes;
        d0 = dones;
        push_exp(16'h0000, 16'h0200);
        do_start(16'h0000, 16'd2);
        send_block(16'h0200, 1'b0);
        for (int k = 0; k < 8; k++) send_word(BW'(16'h0300 + k), 1'b0);
        in_valid = 1'b1;
        in_data = 16'h0308;
        abort = 1'b1;
        @(negedge clock);
        check("abort_ready_same_cycle", 512'(in_ready), 512'(1));
        sync();
        abort = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("abort_idle", 512'({busy, in_ready}), 512'(0));
        end
        check("abort_strobes", 512'(strobes), 512'(s0 + 1));
        check("abort_nodone", 512'(dones), 512'(d0));
        sync();
        push_exp(16'h0040, 16'h0400);
        do_start(16'h0040, 16'd1);
        send_block(16'h0400, 1'b0);
        wait_for_done(d0 + 1, 40);
        check("after_abort_strobes", 512'(strobes), 512'(s0 + 2));
        sync();

        // asynchronous reset mid-FILL
        s0 = strobes;
        do_start(16'h0000, 16'd1);
        for (int k = 0; k < 5; k++) send_word(BW'(16'h0600 + k), 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("arst_flags", 512'({in_ready, loader_write_valid, busy, done, error}), 512'(0));
        check("arst_addr", 512'(loader_write_addr), 512'(0));
        check("arst_data", 512'(loader_write_data), 512'(0));
        #3;
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 16'h0777;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (i % 5 == 0) check("arst_ready_low", 512'(in_ready), 512'(0));
        end
        in_valid = 1'b0;
        check("arst_no_strobe", 512'(strobes), 512'(s0));
        sync();

        // start while busy is ignored
        s0 = strobes;
        d0 = dones;
        e0 = errors;
        push_exp(16'h0080, 16'h0500);
        push_exp(16'h0090, 16'h0510);
        do_start(16'h0080, 16'd2);
        for (int k = 0; k < 32; k++) begin
            if (k == 5 || k == 20) begin
                start = 1'b1;
                base_addr = 16'h0000;
                num_blocks = 16'd5;
            end
            send_word(BW'(16'h0500 + k), 1'b0);
            start = 1'b0;
            base_addr = 16'h0033;
        end
        wait_for_done(d0 + 1, 40);
        check("busy_start_strobes", 512'(strobes), 512'(s0 + 2));
        check("busy_start_errors", 512'(errors), 512'(e0));
        repeat (20) @(negedge clock);
        check("busy_start_no_more", 512'(strobes), 512'(s0 + 2));
        check("final_queue_empty", 512'(exp_q.size()), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
